// File: rtl/reg_file_mp_if.sv
// Bus interface for reg_file_mp: two write ports, two read ports, status flags.
// The master drives writes and read addresses, the slave returns read data and status.
interface reg_file_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  wrEn0;
    logic [ADDR_WIDTH-1:0] rd0;
    logic [DATA_WIDTH-1:0] dIn0;
    logic                  wrEn1;
    logic [ADDR_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] dIn1;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [DATA_WIDTH-1:0] r1;
    logic [DATA_WIDTH-1:0] r2;
    logic                  ready;
    logic                  wrConflict;

    modport master (
        output wrEn0, rd0, dIn0, wrEn1, rd1, dIn1, rs1, rs2,
        input  r1, r2, ready, wrConflict
    );

    modport slave (
        input  wrEn0, rd0, dIn0, wrEn1, rd1, dIn1, rs1, rs2,
        output r1, r2, ready, wrConflict
    );
endinterface

// File: rtl/reg_file_mp.sv
// Two-write / two-read register file with a post-reset clear sequencer.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_mp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clrCnt;
    logic                  readyQ;
    logic                  conflictQ;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic drop0;
    logic drop1;
    logic we0;
    logic we1;
    logic conflict;

    // A write to entry 0 is dropped entirely when it is hardwired to zero, so it
    // can neither land in the array nor raise a conflict.
    assign drop0    = (ZERO_REG != 0) && (bus.rd0 == '0);
    assign drop1    = (ZERO_REG != 0) && (bus.rd1 == '0);
    assign we0      = (state == READY) && bus.wrEn0 && !drop0;
    assign we1      = (state == READY) && bus.wrEn1 && !drop1;
    assign conflict = we0 && we1 && (bus.rd0 == bus.rd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clrCnt    <= '0;
            readyQ    <= 1'b0;
            conflictQ <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    conflictQ <= 1'b0;
                    clrCnt    <= clrCnt + 1'b1;
                    if (&clrCnt) begin
                        state  <= READY;
                        readyQ <= 1'b1;
                    end
                end
                READY: begin
                    conflictQ <= conflict;
                end
                default: begin
                    state  <= CLEAR;
                    clrCnt <= '0;
                    readyQ <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset; it is zeroed by the clear walk. Port 1 is written last,
    // so on an address collision its data is the one that lands.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clrCnt] <= '0;
        end else begin
            if (we0) mem[bus.rd0] <= bus.dIn0;
            if (we1) mem[bus.rd1] <= bus.dIn1;
        end
    end

    logic [ADDR_WIDTH-1:0] rsArr [2];
    logic [DATA_WIDTH-1:0] rOut  [2];

    assign rsArr[0] = bus.rs1;
    assign rsArr[1] = bus.rs2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rOut[p] = mem[rsArr[p]];
`ifdef REGFILE_BYPASS_EN
            if (we1 && (bus.rd1 == rsArr[p])) begin
                rOut[p] = bus.dIn1;
            end else if (we0 && (bus.rd0 == rsArr[p])) begin
                rOut[p] = bus.dIn0;
            end
`endif
            if (!readyQ || ((ZERO_REG != 0) && (rsArr[p] == '0))) begin
                rOut[p] = '0;
            end
        end
    end

    assign bus.r1         = rOut[0];
    assign bus.r2         = rOut[1];
    assign bus.ready      = readyQ;
    assign bus.wrConflict = conflictQ;
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed, table-driven bench for reg_file_mp (DATA_WIDTH=32, ADDR_WIDTH=5, ZERO_REG=1).
module tb_reg_file_mp;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    reg_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wrEn0;
        logic [4:0]  rd0;
        logic [31:0] dIn0;
        logic        wrEn1;
        logic [4:0]  rd1;
        logic [31:0] dIn1;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] expR1;
        logic [31:0] expR2;
        logic        expConflict;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.wrEn0 = v.wrEn0;
        bus.rd0   = v.rd0;
        bus.dIn0  = v.dIn0;
        bus.wrEn1 = v.wrEn1;
        bus.rd1   = v.rd1;
        bus.dIn1  = v.dIn1;
        bus.rs1   = v.rs1;
        bus.rs2   = v.rs2;
    endtask

    // Counts edges from reset release until ready, probing mid-clear outputs once.
    task automatic waitReady(input string name);
        int n;
        n = 0;
        while (!bus.ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 16) begin
                checkOutput({name, "_mid_r1"}, bus.r1, 32'h0);
                checkOutput({name, "_mid_conflict"}, {31'h0, bus.wrConflict}, 32'h0);
                checkOutput({name, "_mid_ready"}, {31'h0, bus.ready}, 32'h0);
            end
        end
        checkOutput({name, "_edges"}, n, 32'd32);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd0,  5'd1, 32'h0,        32'h0,        1'b0};
        vecs[1] = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  32'h0,        5'd5,  5'd0, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[2] = '{1'b1, 5'd7,  32'h00001111, 1'b1, 5'd7,  32'h00002222, 5'd0,  5'd5, 32'h0,        32'hDEADBEEF, 1'b1};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd7, 32'h00002222, 32'h00002222, 1'b0};
        vecs[4] = '{1'b1, 5'd0,  32'h00000099, 1'b1, 5'd0,  32'h00000077, 5'd0,  5'd7, 32'h0,        32'h00002222, 1'b0};
        vecs[5] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd1,  32'h80000000, 5'd7,  5'd5, 32'h00002222, 32'hDEADBEEF, 1'b0};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd31, 5'd1, 32'hFFFFFFFF, 32'h80000000, 1'b0};
        vecs[7] = '{1'b1, 5'd3,  32'h0000AAAA, 1'b1, 5'd3,  32'h0000BBBB, 5'd31, 5'd1, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[8] = '{1'b1, 5'd4,  32'h0000CCCC, 1'b0, 5'd0,  32'h0,        5'd3,  5'd3, 32'h0000BBBB, 32'h0000BBBB, 1'b0};
        vecs[9] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd4,  5'd0, 32'h0000CCCC, 32'h0,        1'b0};

        applyStimulus('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd9, 32'h0, 32'h0, 1'b0});
        rst_n = 1'b0;
        #12;
        checkOutput("reset_ready", {31'h0, bus.ready}, 32'h0);
        checkOutput("reset_conflict", {31'h0, bus.wrConflict}, 32'h0);
        checkOutput("reset_r1", bus.r1, 32'h0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitReady("clear1");
        for (int i = 0; i < 32; i++) begin
            bus.rs1 = 5'(i);
            bus.rs2 = 5'(31 - i);
            #1;
            checkOutput("cleared_r1", bus.r1, 32'h0);
            checkOutput("cleared_r2", bus.r2, 32'h0);
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_r1", i), bus.r1, vecs[i].expR1);
            checkOutput($sformatf("vec%0d_r2", i), bus.r2, vecs[i].expR2);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_conflict", i), {31'h0, bus.wrConflict}, {31'h0, vecs[i].expConflict});
        end
        bus.wrEn0 = 1'b0;
        bus.wrEn1 = 1'b0;

        // Same-cycle write/read of entry 9.
        bus.wrEn1 = 1'b1;
        bus.rd1   = 5'd9;
        bus.dIn1  = 32'hA;
        @(posedge clk);
        #1;
        bus.dIn1 = 32'hB;
        bus.rs2  = 5'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        checkOutput("bypass_same_cycle", bus.r2, 32'hB);
`else
        checkOutput("bypass_same_cycle", bus.r2, 32'hA);
`endif
        @(posedge clk);
        #1;
        bus.wrEn1 = 1'b0;
        #1;
        checkOutput("bypass_next_cycle", bus.r2, 32'hB);

        // Async reset in the middle of a write, with writes driven throughout the clear.
        bus.wrEn0 = 1'b1;
        bus.rd0   = 5'd7;
        bus.dIn0  = 32'h5A5A;
        bus.rs1   = 5'd7;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_ready", {31'h0, bus.ready}, 32'h0);
        checkOutput("async_r1", bus.r1, 32'h0);
        bus.rd0   = 5'd3;
        bus.dIn0  = 32'h55;
        bus.wrEn1 = 1'b1;
        bus.rd1   = 5'd3;
        bus.dIn1  = 32'h66;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitReady("clear2");
        bus.wrEn0 = 1'b0;
        bus.wrEn1 = 1'b0;
        checkOutput("clear2_conflict", {31'h0, bus.wrConflict}, 32'h0);
        bus.rs1 = 5'd7;
        bus.rs2 = 5'd3;
        #1;
        checkOutput("clear2_entry7", bus.r1, 32'h0);
        checkOutput("clear2_entry3", bus.r2, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
